// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers, one shared adder, WIDTH iterations.
// Optional MULDIV_EARLY_OUT_EN: trivial operands skip CALC and go straight to FIX.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  input  logic             iFlush,
  input  logic             iWriteHi,
  input  logic             iWriteLo,
  input  logic [WIDTH-1:0] iWriteData,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_sign_a, r_sign_b, r_b_zero, r_busy, r_done;
  logic [WIDTH-1:0] r_mag_a, r_mag_b, r_acc_hi, r_acc_lo, r_hi, r_lo;
  logic [CW-1:0]    r_cnt;

  logic             w_in_sa, w_in_sb, w_trivial;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_add_y, w_add_x, w_sum;
  logic             w_add_c;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot, w_rem;

  // Issue-side operand magnitudes and the early-out decision
  always_comb begin
    w_in_sa = ~iOp[0] & iOperandA[WIDTH-1];
    w_in_sb = ~iOp[0] & iOperandB[WIDTH-1];
    w_abs_a = w_in_sa ? neg_w(iOperandA) : iOperandA;
    w_abs_b = w_in_sb ? neg_w(iOperandB) : iOperandB;
`ifdef MULDIV_EARLY_OUT_EN
    if (iOp[1]) begin
      w_trivial = (iOperandB == ZERO_W) || (w_abs_a < w_abs_b);
    end else begin
      w_trivial = (w_abs_a == ZERO_W) || (w_abs_b == ZERO_W);
    end
`else
    w_trivial = 1'b0;
`endif
  end

  // Single adder: add multiplicand (mult) or trial-subtract divisor (div); bit WIDTH+1 is the borrow
  always_comb begin
    w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    if (r_op[1]) begin
      w_add_y = {1'b0, w_shift};
      w_add_x = ~{2'b00, r_mag_b};
      w_add_c = 1'b1;
    end else begin
      w_add_y = {2'b00, r_acc_hi};
      w_add_x = {2'b00, r_mag_a};
      w_add_c = 1'b0;
    end
    w_sum = w_add_y + w_add_x + {{(WIDTH+1){1'b0}}, w_add_c};
  end

  // Sign fixup applied on the FIX edge
  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (r_sign_a ^ r_sign_b) begin
      w_prod = neg_2w({r_acc_hi, r_acc_lo});
    end else begin
      w_prod = {r_acc_hi, r_acc_lo};
    end
    if (r_b_zero) begin
      w_quot = {WIDTH{1'b1}};
    end else if (r_sign_a ^ r_sign_b) begin
      w_quot = neg_w(r_acc_lo);
    end else begin
      w_quot = r_acc_lo;
    end
    w_rem = r_sign_a ? neg_w(r_acc_hi) : r_acc_hi;
  end

  // Sequencer FSM, datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mag_a  <= ZERO_W;
      r_mag_b  <= ZERO_W;
      r_acc_hi <= ZERO_W;
      r_acc_lo <= ZERO_W;
      r_hi     <= ZERO_W;
      r_lo     <= ZERO_W;
      r_cnt    <= {CW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iWriteHi) r_hi <= iWriteData;
          if (iWriteLo) r_lo <= iWriteData;
          if (iStart && !iFlush) begin
            r_op     <= iOp;
            r_sign_a <= w_in_sa;
            r_sign_b <= w_in_sb;
            r_b_zero <= (iOperandB == ZERO_W);
            r_mag_a  <= w_abs_a;
            r_mag_b  <= w_abs_b;
            // Early-out preload already holds the final magnitudes (remainder = |A|)
            r_acc_hi <= (w_trivial && iOp[1]) ? w_abs_a : ZERO_W;
            r_acc_lo <= w_trivial ? ZERO_W : (iOp[1] ? w_abs_a : w_abs_b);
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= w_trivial ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (iFlush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_op[1]) begin
              if (!w_sum[WIDTH+1]) begin
                r_acc_hi <= w_sum[WIDTH-1:0];
                r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
              end else begin
                r_acc_hi <= w_shift[WIDTH-1:0];
                r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
              end
            end else if (r_acc_lo[0]) begin
              {r_acc_hi, r_acc_lo} <= {w_sum[WIDTH:0], r_acc_lo[WIDTH-1:1]};
            end else begin
              {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!iFlush) begin
            if (r_op[1]) begin
              r_lo <= w_quot;
              r_hi <= w_rem;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_done <= 1'b1;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy = r_busy;
  assign oDone = r_done;
  assign oHi   = r_hi;
  assign oLo   = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus flush/reset/write corner sequences.
module tb_muldiv_sequencer;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, iStart, iFlush, iWriteHi, iWriteLo;
  logic [1:0]   iOp;
  logic [W-1:0] iOperandA, iOperandB, iWriteData;
  logic         oBusy, oDone;
  logic [W-1:0] oHi, oLo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          triv;
  } vec_t;
  vec_t vecs [12];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iOp(iOp),
    .iOperandA(iOperandA), .iOperandB(iOperandB), .iFlush(iFlush),
    .iWriteHi(iWriteHi), .iWriteLo(iWriteLo), .iWriteData(iWriteData),
    .oBusy(oBusy), .oDone(oDone), .oHi(oHi), .oLo(oLo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at the next edge, wait for oDone, check latency, busy span, result and pulse width.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit triv,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int k, busy_n, exp_lat;
    @(negedge clk);
    iStart = 1'b1; iOp = op; iOperandA = a; iOperandB = b;
    @(negedge clk);
    iStart = 1'b0;
    k = 0; busy_n = 0;
    while (!oDone && k < 200) begin
      if (oBusy) busy_n++;
      @(negedge clk);
      k++;
    end
    exp_lat = (EARLY && triv) ? 1 : W + 1;
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " busy cycles"}, busy_n, exp_lat);
    chk({tag, " busy at done"}, {31'd0, oBusy}, 32'd0);
    chk({tag, " HI"}, oHi, ehi);
    chk({tag, " LO"}, oLo, elo);
    @(negedge clk);
    chk({tag, " done pulse width"}, {31'd0, oDone}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b10, 32'h00000003, 32'h0000000A, 32'h00000003, 32'h00000000, 1'b1};
    vecs[6]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b00, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b1};
    vecs[8]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    reset = 1'b1; iStart = 1'b0; iOp = 2'b00; iOperandA = '0; iOperandB = '0;
    iFlush = 1'b0; iWriteHi = 1'b0; iWriteLo = 1'b0; iWriteData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset HI", oHi, 32'd0);
    chk("reset LO", oLo, 32'd0);
    chk("reset busy/done", {30'd0, oBusy, oDone}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].triv,
             vecs[i].hi, vecs[i].lo);
    end

    // mthi/mtlo, then a flushed divide with an ignored iStart and ignored write mid-run
    @(negedge clk); iWriteHi = 1'b1; iWriteData = 32'hCAFEF00D;
    @(negedge clk); iWriteHi = 1'b0; iWriteLo = 1'b1; iWriteData = 32'h12345678;
    @(negedge clk); iWriteLo = 1'b0;
    chk("mthi", oHi, 32'hCAFEF00D);
    chk("mtlo", oLo, 32'h12345678);
    iStart = 1'b1; iOp = 2'b10; iOperandA = 32'd100; iOperandB = 32'd7;
    @(negedge clk); iStart = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) begin
        iStart = 1'b1; iOp = 2'b01; iWriteLo = 1'b1; iWriteData = 32'h0000DEAD;
      end else begin
        iStart = 1'b0; iWriteLo = 1'b0;
      end
      if (k == 10) iFlush = 1'b1;
    end
    @(negedge clk); iFlush = 1'b0;
    chk("flush busy low", {31'd0, oBusy}, 32'd0);
    chk("flush LO kept", oLo, 32'h12345678);
    chk("flush HI kept", oHi, 32'hCAFEF00D);
    begin
      int seen_done, seen_busy;
      seen_done = 0; seen_busy = 0;
      for (int k = 0; k < 40; k++) begin
        if (oDone) seen_done++;
        if (oBusy) seen_busy++;
        @(negedge clk);
      end
      chk("flush no done", seen_done, 0);
      chk("flush no restart", seen_busy, 0);
    end

    // iFlush in IDLE suppresses a coincident iStart
    iStart = 1'b1; iFlush = 1'b1; iOp = 2'b01; iOperandA = 32'd4; iOperandB = 32'd4;
    @(negedge clk); iStart = 1'b0; iFlush = 1'b0;
    chk("idle flush blocks start", {31'd0, oBusy}, 32'd0);

    // mtlo coincident with iStart: write lands now, result overwrites later
    iStart = 1'b1; iOp = 2'b01; iOperandA = 32'd2; iOperandB = 32'd3;
    iWriteLo = 1'b1; iWriteData = 32'h55AA55AA;
    @(negedge clk); iStart = 1'b0; iWriteLo = 1'b0;
    chk("start+mtlo LO now", oLo, 32'h55AA55AA);
    begin
      int k;
      k = 0;
      while (!oDone && k < 200) begin @(negedge clk); k++; end
      chk("start+mtlo done seen", {31'd0, oDone}, 32'd1);
      chk("start+mtlo LO result", oLo, 32'd6);
      chk("start+mtlo HI result", oHi, 32'd0);
    end

    // Reset in the middle of CALC
    @(negedge clk);
    iStart = 1'b1; iOp = 2'b00; iOperandA = 32'd9; iOperandB = 32'd9;
    @(negedge clk); iStart = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", {31'd0, oBusy}, 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midreset HI", oHi, 32'd0);
    chk("midreset LO", oLo, 32'd0);
    chk("midreset busy", {31'd0, oBusy}, 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
        if (oDone) seen_done++;
        @(negedge clk);
      end
      chk("midreset no done", seen_done, 0);
    end
    run_op("mult 5x6", 2'b00, 32'd5, 32'd6, 1'b0, 32'd0, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
